// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, FSM state type and opcode helpers
package alu_pkg;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } alu_state_t;

    function automatic logic is_sub(input logic [5:0] op);
        return (op == FN_SUB) || (op == FN_SLT);
    endfunction

    function automatic logic is_arith(input logic [5:0] op);
        return (op == FN_ADD) || is_sub(op);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// rtl/alu_digit.sv - combinational DIGIT-bit slice: logic ops, add, subtract
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic [5:0]       op,
    output logic [DIGIT-1:0] res,
    output logic             cout,
    output logic             cin_msb
);

    logic [DIGIT-1:0] b_eff;
    logic [DIGIT:0]   sum;

    always_comb begin
        b_eff   = is_sub(op) ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};
        cout    = sum[DIGIT];
        // Recover the carry into the top bit from the sum bit and its two addends.
        cin_msb = a[DIGIT-1] ^ b_eff[DIGIT-1] ^ sum[DIGIT-1];
        case (op)
            FN_AND:                 res = a & b;
            FN_OR:                  res = a | b;
            FN_ADD, FN_SUB, FN_SLT: res = sum[DIGIT-1:0];
            default:                res = '0;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - digit-serial integer ALU with valid/ready on both sides
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("alu_serial: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    alu_state_t       state;
    alu_state_t       state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [5:0]       op_r;
    logic             carry_r;
    logic [CW-1:0]    cnt;
    logic             cout_r;
    logic             ovf_r;
    logic             last;
    logic [WIDTH-1:0] result;

    logic [DIGIT-1:0] d_res;
    logic             d_cout;
    logic             d_cin_msb;

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a       (a_sr[DIGIT-1:0]),
        .b       (b_sr[DIGIT-1:0]),
        .cin     (carry_r),
        .op      (op_r),
        .res     (d_res),
        .cout    (d_cout),
        .cin_msb (d_cin_msb)
    );

    assign last = (state == ST_RUN) && (cnt == CW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            op_r    <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr    <= dataA;
                        b_sr    <= dataB;
                        res_sr  <= '0;
                        op_r    <= Signal;
                        carry_r <= is_sub(Signal);
                        cnt     <= '0;
                        cout_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Operands drain from the bottom; result digits enter at the top.
                    a_sr    <= a_sr >> DIGIT;
                    b_sr    <= b_sr >> DIGIT;
                    res_sr  <= (res_sr >> DIGIT) | (WIDTH'(d_res) << (WIDTH - DIGIT));
                    carry_r <= d_cout;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        cout_r <= is_arith(op_r) & d_cout;
                        ovf_r  <= is_arith(op_r) & (d_cin_msb ^ d_cout);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (op_r)
            FN_SLT:                 result = WIDTH'(res_sr[WIDTH-1] ^ ovf_r);
            FN_AND, FN_OR, FN_ADD,
            FN_SUB:                 result = res_sr;
            default:                result = '0;
        endcase
    end

    // Outputs are forced to their idle values unless a finished result is on offer.
    assign dataOut  = out_valid ? result : '0;
    assign cout     = out_valid & cout_r;
    assign overflow = out_valid & ovf_r;
    assign zero     = (dataOut == '0);

endmodule
